// File: rtl/fix_rx_pkg.sv
// Shared constants and state type for the FIX receive framer.
package fix_rx_pkg;

    // Framing characters
    localparam logic [7:0] SOH    = 8'h01;
    localparam logic [7:0] ASC_8  = 8'h38;
    localparam logic [7:0] ASC_1  = 8'h31;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_EQ = 8'h3D;
    localparam logic [7:0] ASC_9  = 8'h39;

    // '1' + '0' + '=' : removes the "10=" tag from the running sum
    localparam logic [7:0] TAG_SUM_ADJ = 8'h9E;

    typedef enum logic [3:0] {
        StIdle,
        StBody,
        StT1,
        StT0,
        StTeq,
        StD0,
        StD1,
        StD2,
        StTend
    } rx_state_t;

endpackage

// File: rtl/fix_rx_ram.sv
// Simple dual-port DEPTH x WIDTH RAM, one write and one registered read per cycle.
module fix_rx_ram #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; read-during-write returns the old contents
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/fix_rx_msg_buffer.sv
// Store-and-forward FIX receive framer: delimits, checksums and buffers whole messages,
// exposing only committed messages to the engine as a first-word-fall-through stream.
module fix_rx_msg_buffer
    import fix_rx_pkg::*;
#(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned MAX_LEN = 256,
    parameter int unsigned CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic [7:0]    message_i,
    input  logic          rd_i,
    output logic          new_message_o,
    output logic [7:0]    message_o,
    output logic          msg_valid_o,
    output logic          msg_last_o,
    output logic [CW-1:0] msg_count_o,
    output logic [15:0]   drop_count_o,
    output logic          cksum_err_o,
    output logic          overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    rx_state_t         state_q, state_n;
    logic [PW-1:0]     wr_ptr_q, commit_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [7:0]        sum_q, ck_sum_q;
    logic [9:0]        ck_val_q;
    logic [LW-1:0]     len_q;
    logic              drop_flag_q;
    logic [15:0]       drop_count_q;
    logic [CW-1:0]     msg_count_q;
    logic              cksum_err_q, overflow_q;

    logic              is_soh, is_digit, in_digits, ck_match;
    logic              want_write, full, len_ovf, ovf, ck_bad, commit, wr_en;
    logic              pop, pop_last;
    logic [8:0]        rdata;

    // Per-byte decode: next framing state and the write/commit/drop decision
    always_comb begin
        is_soh     = (message_i == SOH);
        is_digit   = (message_i >= ASC_0) && (message_i <= ASC_9);
        in_digits  = (state_q == StD0) || (state_q == StD1) || (state_q == StD2);
        ck_match   = (ck_val_q[7:0] == ck_sum_q);
        // Uncommitted bytes are only written outside drop mode and once a message has started
        want_write = valid_i && !drop_flag_q && ((state_q != StIdle) || (message_i == ASC_8));
        full       = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
        len_ovf    = (state_q != StIdle) && (len_q >= LW'(MAX_LEN));
        ovf        = want_write && (full || len_ovf);
        ck_bad     = want_write && !ovf &&
                     ((in_digits && !is_digit) ||
                      ((state_q == StTend) && !(is_soh && ck_match)));
        commit     = want_write && !ovf && (state_q == StTend) && is_soh && ck_match;
        wr_en      = want_write && !ovf;

        state_n = state_q;
        unique case (state_q)
            StIdle:  state_n = (message_i == ASC_8) ? StBody : StIdle;
            StBody:  state_n = is_soh ? StT1 : StBody;
            StT1:    state_n = (message_i == ASC_1) ? StT0 : (is_soh ? StT1 : StBody);
            StT0:    state_n = (message_i == ASC_0) ? StTeq : (is_soh ? StT1 : StBody);
            StTeq:   state_n = (message_i == ASC_EQ) ? StD0 : (is_soh ? StT1 : StBody);
            StD0:    state_n = is_digit ? StD1 : (is_soh ? StT1 : StBody);
            StD1:    state_n = is_digit ? StD2 : (is_soh ? StT1 : StBody);
            StD2:    state_n = is_digit ? StTend : (is_soh ? StT1 : StBody);
            StTend:  state_n = StIdle;
            default: state_n = StIdle;
        endcase
    end

    // Framer FSM with write pointer, checksum accumulation, commit and drop handling
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            sum_q        <= '0;
            ck_sum_q     <= '0;
            ck_val_q     <= '0;
            len_q        <= '0;
            drop_flag_q  <= 1'b0;
            drop_count_q <= '0;
            cksum_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            cksum_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            if (valid_i) begin
                state_q <= state_n;
                if ((state_q == StTeq) && (message_i == ASC_EQ)) begin
                    ck_sum_q <= sum_q + message_i - TAG_SUM_ADJ;
                    ck_val_q <= '0;
                end
                if (in_digits && is_digit) begin
                    ck_val_q <= ck_val_q * 10'd10 + {6'b0, message_i[3:0]};
                end
                if (drop_flag_q) begin
                    // Discarding: wait for the trailer of the dropped message
                    if (state_q == StTend) begin
                        drop_flag_q <= 1'b0;
                    end
                end else if (ovf || ck_bad) begin
                    wr_ptr_q    <= commit_ptr_q;
                    overflow_q  <= ovf;
                    cksum_err_q <= ck_bad;
                    drop_flag_q <= (state_q != StTend);
                    if (drop_count_q != 16'hFFFF) begin
                        drop_count_q <= drop_count_q + 16'd1;
                    end
                end else if (want_write) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (state_q == StIdle) begin
                        sum_q <= message_i;
                        len_q <= LW'(1);
                    end else begin
                        sum_q <= sum_q + message_i;
                        len_q <= len_q + 1'b1;
                    end
                    if (commit) begin
                        commit_ptr_q <= wr_ptr_q + 1'b1;
                    end
                end
            end
        end
    end

    fix_rx_ram #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({commit, message_i}),
        .raddr_i (rd_ptr_d[AW-1:0]),
        .rdata_o (rdata)
    );

    // Read address runs one pop ahead so the RAM register always holds the head entry
    assign msg_valid_o = (rd_ptr_q != commit_ptr_q);
    assign pop         = rd_i && msg_valid_o;
    assign pop_last    = pop && rdata[8];
    assign rd_ptr_d    = rd_ptr_q + PW'(pop);

    // Read pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Committed-message count; a commit and a last-byte pop together cancel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_count_q <= '0;
        end else if (commit && !pop_last) begin
            if (msg_count_q != {CW{1'b1}}) begin
                msg_count_q <= msg_count_q + 1'b1;
            end
        end else if (pop_last && !commit) begin
            if (msg_count_q != '0) begin
                msg_count_q <= msg_count_q - 1'b1;
            end
        end
    end

    assign message_o     = msg_valid_o ? rdata[7:0] : 8'h00;
    assign msg_last_o    = msg_valid_o && rdata[8];
    assign msg_count_o   = msg_count_q;
    assign new_message_o = (msg_count_q != '0);
    assign drop_count_o  = drop_count_q;
    assign cksum_err_o   = cksum_err_q;
    assign overflow_o    = overflow_q;

endmodule
